lc3_control: RTL
================

Name: lc3_control

Overview:
- Multicycle LC-3 sequencer FSM driving every control input of the LC-3 datapath (bus enables, load strobes, mux selects, register addresses).
- Reads IR and the N/Z/P flags back from the datapath and steps each instruction through fetch, decode and execute.
- Also produces the memory write strobe and wait timing for a fixed-latency memory.

Parameters:
- MEM_LAT, 1, cycles per memory read or write access (legal range 1..15)

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- run  input  1  sampled only in FETCH0; 0 holds the FSM idle in FETCH0
- IR  input  16  instruction register from the datapath
- N, Z, P  input  1 each  condition flags from the datapath
- enaPC, enaMDR, enaALU, enaMARM  output  1 each  bus drivers; at most one high in any cycle
- ldPC, ldIR, ldMAR, ldMDR  output  1 each  register load strobes
- selMDR  output  1  1 = MDR from memory, 0 = MDR from bus
- selMAR  output  1  1 = MARM passes IR[7:0], 0 = EAB sum
- selEAB1  output  1  0 = PC, 1 = SR1 output
- selEAB2  output  2  0 = zero, 1 = sext IR[5:0], 2 = sext IR[8:0], 3 = sext IR[10:0]
- selPC  output  2  0 = PC+1, 1 = EAB, 2 = bus
- aluControl  output  2  0 ADD, 1 AND, 2 NOT, 3 PASS
- regWE, flagWE  output  1 each  register file and NZP write enables
- SR1, SR2, DR  output  3 each  register file addresses
- memWE  output  1  memory write strobe
- instr_done  output  1  one-cycle pulse in the last cycle of each instruction
- illegal  output  1  one-cycle pulse in DECODE on an unsupported opcode

Behaviour:
- Outputs are combinational from the state register and IR. Every strobe defaults to 0; SR1/SR2/DR/selects default to 0.
- Reset: rst high asynchronously forces state FETCH0 and wait counter 0. While rst is high, all outputs are 0. The first cycle after release is FETCH0.
- FETCH0:
  - If run=0: stay, no strobes.
  - Else enaPC, ldMAR, ldPC, selPC=0; go to FETCH1.
- FETCH1: count MEM_LAT cycles. On the final cycle assert ldMDR and selMDR=1, then go to FETCH2.
- FETCH2: enaMDR, ldIR; go to DECODE.
- DECODE: one cycle with no strobes; dispatch on IR[15:12]:
  - ADD (0001), AND (0101), NOT (1001) -> EXEC_ALU
  - BR (0000) -> BR
  - JMP (1100) -> JMP
  - LEA (1110) -> LEA
  - LD (0010), LDR (0110), ST (0011), STR (0111) -> ADDR
  - Any other opcode: illegal=1, instr_done=1, go to FETCH0 (executes as a NOP).
- EXEC_ALU: SR1=IR[8:6], SR2=IR[2:0], DR=IR[11:9], aluControl per opcode, enaALU, regWE, flagWE.
- BR:
  - Taken when (IR[11]&N) | (IR[10]&Z) | (IR[9]&P).
  - If taken: ldPC, selPC=1, selEAB1=0, selEAB2=2.
  - nzp=000 or IR[11:9]=000 means never taken.
- JMP: SR1=IR[8:6], selEAB1=1, selEAB2=0, ldPC, selPC=1.
- LEA: enaMARM, selMAR=0, selEAB1=0, selEAB2=2, DR=IR[11:9], regWE, flagWE.
- ADDR: enaMARM, selMAR=0, ldMAR.
  - LD/ST: selEAB1=0, selEAB2=2.
  - LDR/STR: selEAB1=1, SR1=IR[8:6], selEAB2=1.
  - Loads go to MEMRD; stores go to ST_DATA.
- MEMRD: wait MEM_LAT cycles. The final cycle asserts ldMDR, selMDR=1; go to WB.
- WB: enaMDR, DR=IR[11:9], regWE, flagWE.
- ST_DATA: SR1=IR[11:9], selEAB1=1, selEAB2=0, selMAR=0, enaMARM, ldMDR, selMDR=0; go to MEMWR.
- MEMWR: memWE high for exactly MEM_LAT cycles, then done.
- Every execute-path terminal state (EXEC_ALU, BR, JMP, LEA, WB, last MEMWR cycle, last TRAP state) asserts instr_done and returns to FETCH0.
- Wait counter: reloads to 0 on entry to every wait state and never wraps past MEM_LAT-1.
- Reset asserted mid-instruction aborts immediately with no further strobes; the partial instruction is discarded.

Optional Feature:
- Macro: LC3_TRAP_EN
- Defined: opcode 1111 executes TRAP.
  - TRAP0: enaMARM, selMAR=1, ldMAR.
  - TRAP1: enaPC, DR=7, regWE (no flagWE).
  - TRAPRD: read wait of MEM_LAT cycles, ending with ldMDR, selMDR=1.
  - TRAP2: enaMDR, ldPC, selPC=2, instr_done.
- Undefined: 1111 is illegal like other unsupported opcodes.

Test Plan:
- MEM_LAT=1, run=1, IR=0x1042 (ADD R0,R1,R2) -> FETCH0..EXEC_ALU takes exactly 5 cycles; EXEC_ALU shows SR1=1, SR2=2, DR=0, enaALU/regWE/flagWE=1; instr_done in cycle 5.
- IR=0x0E05 (BRnzp) with Z=1 -> BR cycle ldPC=1, selPC=1, selEAB2=2. IR=0x0805 (BRn) with Z=1 -> ldPC=0.
- MEM_LAT=3, IR=0x2203 (LD R1) -> 11 cycles total; ldMDR+selMDR only on the last MEMRD cycle; WB shows DR=1, enaMDR=1.
- IR=0x7283 (STR R1,R2,#3) -> ADDR selEAB1=1, SR1=2, selEAB2=1; ST_DATA SR1=1, ldMDR, selMDR=0; memWE high for MEM_LAT cycles.
- IR=0xD000 -> illegal pulse in DECODE, then FETCH0. run=0 -> no strobes for 20 cycles; rst asserted mid-MEMRD -> all outputs 0 in the same cycle, restart in FETCH0.
- With LC3_TRAP_EN, IR=0xF025 -> selMAR=1/ldMAR, then R7 write (DR=7), then PC load with selPC=2; without the macro -> illegal pulse.

Source files
------------

// File: rtl/lc3_control_if.sv
// Datapath-side signal bundle for the LC-3 sequencer. The master side is the control FSM.
// The slave side is the datapath, which returns IR and the N/Z/P flags.
interface lc3_control_if;
  logic [15:0] IR;
  logic        N;
  logic        Z;
  logic        P;
  logic        enaPC;
  logic        enaMDR;
  logic        enaALU;
  logic        enaMARM;
  logic        ldPC;
  logic        ldIR;
  logic        ldMAR;
  logic        ldMDR;
  logic        selMDR;
  logic        selMAR;
  logic        selEAB1;
  logic [1:0]  selEAB2;
  logic [1:0]  selPC;
  logic [1:0]  aluControl;
  logic        regWE;
  logic        flagWE;
  logic [2:0]  SR1;
  logic [2:0]  SR2;
  logic [2:0]  DR;
  logic        memWE;
  logic        instr_done;
  logic        illegal;

  modport master (
    input  IR, N, Z, P,
    output enaPC, enaMDR, enaALU, enaMARM,
    output ldPC, ldIR, ldMAR, ldMDR,
    output selMDR, selMAR, selEAB1, selEAB2, selPC, aluControl,
    output regWE, flagWE, SR1, SR2, DR,
    output memWE, instr_done, illegal
  );

  modport slave (
    output IR, N, Z, P,
    input  enaPC, enaMDR, enaALU, enaMARM,
    input  ldPC, ldIR, ldMAR, ldMDR,
    input  selMDR, selMAR, selEAB1, selEAB2, selPC, aluControl,
    input  regWE, flagWE, SR1, SR2, DR,
    input  memWE, instr_done, illegal
  );
endinterface

// File: rtl/lc3_control.sv
// Multicycle LC-3 control sequencer: fetch/decode/execute FSM with fixed-latency memory waits.
// Defining LC3_TRAP_EN adds execution of opcode 1111 (TRAP); otherwise it decodes as illegal.
module lc3_control #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  lc3_control_if.master   dp
);

  typedef enum logic [4:0] {
    S_FETCH0,
    S_FETCH1,
    S_FETCH2,
    S_DECODE,
    S_EXEC_ALU,
    S_BR,
    S_JMP,
    S_LEA,
    S_ADDR,
    S_MEMRD,
    S_WB,
    S_ST_DATA,
    S_MEMWR
`ifdef LC3_TRAP_EN
    , S_TRAP0,
    S_TRAP1,
    S_TRAPRD,
    S_TRAP2
`endif
  } state_e;

  localparam logic [3:0] CNT_LAST = 4'(MEM_LAT - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] opcode;
  logic       wait_last;
  logic       br_taken;
  logic       unused_ir;

  assign opcode    = dp.IR[15:12];
  assign wait_last = (cnt_q == CNT_LAST);
  assign br_taken  = (dp.IR[11] & dp.N) | (dp.IR[10] & dp.Z) | (dp.IR[9] & dp.P);
  assign unused_ir = ^dp.IR[5:3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Counter defaults to 0 so every wait state is entered with a fresh count.
  always_comb begin
    state_d       = state_q;
    cnt_d         = '0;
    dp.enaPC      = 1'b0;
    dp.enaMDR     = 1'b0;
    dp.enaALU     = 1'b0;
    dp.enaMARM    = 1'b0;
    dp.ldPC       = 1'b0;
    dp.ldIR       = 1'b0;
    dp.ldMAR      = 1'b0;
    dp.ldMDR      = 1'b0;
    dp.selMDR     = 1'b0;
    dp.selMAR     = 1'b0;
    dp.selEAB1    = 1'b0;
    dp.selEAB2    = 2'd0;
    dp.selPC      = 2'd0;
    dp.aluControl = 2'd0;
    dp.regWE      = 1'b0;
    dp.flagWE     = 1'b0;
    dp.SR1        = 3'd0;
    dp.SR2        = 3'd0;
    dp.DR         = 3'd0;
    dp.memWE      = 1'b0;
    dp.instr_done = 1'b0;
    dp.illegal    = 1'b0;

    if (!rst) begin
      case (state_q)
        S_FETCH0: begin
          if (run) begin
            dp.enaPC = 1'b1;
            dp.ldMAR = 1'b1;
            dp.ldPC  = 1'b1;
            dp.selPC = 2'd0;
            state_d  = S_FETCH1;
          end
        end

        S_FETCH1: begin
          if (wait_last) begin
            dp.ldMDR  = 1'b1;
            dp.selMDR = 1'b1;
            state_d   = S_FETCH2;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end

        S_FETCH2: begin
          dp.enaMDR = 1'b1;
          dp.ldIR   = 1'b1;
          state_d   = S_DECODE;
        end

        S_DECODE: begin
          case (opcode)
            4'b0001, 4'b0101, 4'b1001:          state_d = S_EXEC_ALU;
            4'b0000:                            state_d = S_BR;
            4'b1100:                            state_d = S_JMP;
            4'b1110:                            state_d = S_LEA;
            4'b0010, 4'b0110, 4'b0011, 4'b0111: state_d = S_ADDR;
`ifdef LC3_TRAP_EN
            4'b1111:                            state_d = S_TRAP0;
`endif
            default: begin
              dp.illegal    = 1'b1;
              dp.instr_done = 1'b1;
              state_d       = S_FETCH0;
            end
          endcase
        end

        S_EXEC_ALU: begin
          dp.SR1    = dp.IR[8:6];
          dp.SR2    = dp.IR[2:0];
          dp.DR     = dp.IR[11:9];
          case (opcode)
            4'b0101: dp.aluControl = 2'd1;
            4'b1001: dp.aluControl = 2'd2;
            default: dp.aluControl = 2'd0;
          endcase
          dp.enaALU     = 1'b1;
          dp.regWE      = 1'b1;
          dp.flagWE     = 1'b1;
          dp.instr_done = 1'b1;
          state_d       = S_FETCH0;
        end

        S_BR: begin
          if (br_taken) begin
            dp.ldPC    = 1'b1;
            dp.selPC   = 2'd1;
            dp.selEAB1 = 1'b0;
            dp.selEAB2 = 2'd2;
          end
          dp.instr_done = 1'b1;
          state_d       = S_FETCH0;
        end

        S_JMP: begin
          dp.SR1        = dp.IR[8:6];
          dp.selEAB1    = 1'b1;
          dp.selEAB2    = 2'd0;
          dp.ldPC       = 1'b1;
          dp.selPC      = 2'd1;
          dp.instr_done = 1'b1;
          state_d       = S_FETCH0;
        end

        S_LEA: begin
          dp.enaMARM    = 1'b1;
          dp.selMAR     = 1'b0;
          dp.selEAB1    = 1'b0;
          dp.selEAB2    = 2'd2;
          dp.DR         = dp.IR[11:9];
          dp.regWE      = 1'b1;
          dp.flagWE     = 1'b1;
          dp.instr_done = 1'b1;
          state_d       = S_FETCH0;
        end

        // IR[14] selects base-register addressing; IR[12] separates stores from loads.
        S_ADDR: begin
          dp.enaMARM = 1'b1;
          dp.selMAR  = 1'b0;
          dp.ldMAR   = 1'b1;
          if (dp.IR[14]) begin
            dp.selEAB1 = 1'b1;
            dp.SR1     = dp.IR[8:6];
            dp.selEAB2 = 2'd1;
          end else begin
            dp.selEAB1 = 1'b0;
            dp.selEAB2 = 2'd2;
          end
          state_d = dp.IR[12] ? S_ST_DATA : S_MEMRD;
        end

        S_MEMRD: begin
          if (wait_last) begin
            dp.ldMDR  = 1'b1;
            dp.selMDR = 1'b1;
            state_d   = S_WB;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end

        S_WB: begin
          dp.enaMDR     = 1'b1;
          dp.DR         = dp.IR[11:9];
          dp.regWE      = 1'b1;
          dp.flagWE     = 1'b1;
          dp.instr_done = 1'b1;
          state_d       = S_FETCH0;
        end

        S_ST_DATA: begin
          dp.SR1     = dp.IR[11:9];
          dp.selEAB1 = 1'b1;
          dp.selEAB2 = 2'd0;
          dp.selMAR  = 1'b0;
          dp.enaMARM = 1'b1;
          dp.ldMDR   = 1'b1;
          dp.selMDR  = 1'b0;
          state_d    = S_MEMWR;
        end

        S_MEMWR: begin
          dp.memWE = 1'b1;
          if (wait_last) begin
            dp.instr_done = 1'b1;
            state_d       = S_FETCH0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end

`ifdef LC3_TRAP_EN
        S_TRAP0: begin
          dp.enaMARM = 1'b1;
          dp.selMAR  = 1'b1;
          dp.ldMAR   = 1'b1;
          state_d    = S_TRAP1;
        end

        S_TRAP1: begin
          dp.enaPC = 1'b1;
          dp.DR    = 3'd7;
          dp.regWE = 1'b1;
          state_d  = S_TRAPRD;
        end

        S_TRAPRD: begin
          if (wait_last) begin
            dp.ldMDR  = 1'b1;
            dp.selMDR = 1'b1;
            state_d   = S_TRAP2;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end

        S_TRAP2: begin
          dp.enaMDR     = 1'b1;
          dp.ldPC       = 1'b1;
          dp.selPC      = 2'd2;
          dp.instr_done = 1'b1;
          state_d       = S_FETCH0;
        end
`endif

        default: state_d = S_FETCH0;
      endcase
    end
  end

endmodule
